// File: rtl/mac_pkg.sv
// Shared definitions for the MAC divider: FSM state encoding and counter sizing.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Step-counter width for a P-bit divide; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned p);
        return (p < 2) ? 1 : $clog2(p);
    endfunction

endpackage

// File: rtl/mac_seq_divider_if.sv
// Operand/result handshake bundle for mac_seq_divider.
// DivZero is present only when DIV_ZERO_FLAG_EN is defined.
interface mac_seq_divider_if #(
    parameter int unsigned P = 8
);
    logic         InValid;
    logic         InReady;
    logic [P-1:0] Dividend;
    logic [P-1:0] Divisor;
    logic         OutValid;
    logic         OutReady;
    logic [P-1:0] Quotient;
    logic [P-1:0] Remainder;
`ifdef DIV_ZERO_FLAG_EN
    logic         DivZero;
`endif

    modport slave (
        input  InValid, Dividend, Divisor, OutReady,
`ifdef DIV_ZERO_FLAG_EN
        output DivZero,
`endif
        output InReady, OutValid, Quotient, Remainder
    );

    modport master (
        output InValid, Dividend, Divisor, OutReady,
`ifdef DIV_ZERO_FLAG_EN
        input  DivZero,
`endif
        input  InReady, OutValid, Quotient, Remainder
    );

endinterface

// File: rtl/Full_Adder_P_bit.sv
// Ripple-carry adder, W bits wide, with carry in and carry out.
module Full_Adder_P_bit #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry_c;

    always_comb begin
        carry_c    = '0;
        sum        = '0;
        carry_c[0] = cin;
        for (int i = 0; i < int'(W); i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry_c[i];
            carry_c[i+1] = (a[i] & b[i]) | (carry_c[i] & (a[i] ^ b[i]));
        end
        cout = carry_c[W];
    end

endmodule

// File: rtl/mac_seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional DivZero flag output is enabled by defining DIV_ZERO_FLAG_EN.
module mac_seq_divider
    import mac_pkg::*;
#(
    parameter int unsigned P = 8
) (
    input  logic              CLK,
    input  logic              RST,
    mac_seq_divider_if.slave  bus
);

    localparam int unsigned      CNT_W    = cnt_w(P);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P - 1);

    state_e           state_q, state_d;
    logic [P-1:0]     q_q, q_d;
    logic [P:0]       r_q, r_d;
    logic [P-1:0]     d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [P-1:0]     quot_q, quot_d;
    logic [P-1:0]     rem_q, rem_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [P:0]       rs_c;
    logic [P:0]       sub_b_c;
    logic [P:0]       t_c;
    logic             no_borrow_c;
    logic             unused_r_msb_c;

    // Trial subtract Rs - D done as Rs + ~{0,D} + 1; carry-out high means no borrow.
    assign rs_c    = {r_q[P-1:0], q_q[P-1]};
    assign sub_b_c = ~{1'b0, d_q};

    Full_Adder_P_bit #(
        .W (P + 1)
    ) u_trial_sub (
        .a    (rs_c),
        .b    (sub_b_c),
        .cin  (1'b1),
        .sum  (t_c),
        .cout (no_borrow_c)
    );

    // The partial remainder stays below the divisor, so its top bit never feeds the next shift.
    assign unused_r_msb_c = r_q[P];

`ifdef DIV_ZERO_FLAG_EN
    logic div_zero_q, div_zero_d;
`endif

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        r_d         = r_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef DIV_ZERO_FLAG_EN
        div_zero_d  = div_zero_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (bus.InValid && in_ready_q) begin
                    q_d        = bus.Dividend;
                    r_d        = '0;
                    d_d        = bus.Divisor;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_BUSY;
`ifdef DIV_ZERO_FLAG_EN
                    div_zero_d = (bus.Divisor == '0);
`endif
                end
            end

            ST_BUSY: begin
                r_d   = no_borrow_c ? t_c : rs_c;
                q_d   = {q_q[P-2:0], no_borrow_c};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    quot_d      = q_d;
                    rem_d       = r_d[P-1:0];
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_valid_q && bus.OutReady) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_q  <= div_zero_d;
`endif
        end
    end

    assign bus.InReady   = in_ready_q;
    assign bus.OutValid  = out_valid_q;
    assign bus.Quotient  = quot_q;
    assign bus.Remainder = rem_q;
`ifdef DIV_ZERO_FLAG_EN
    assign bus.DivZero   = div_zero_q;
`endif

endmodule

// File: tb/tb_mac_seq_divider.sv
// Bench for mac_seq_divider at P=4, 8 and 16; reference is plain a/b and a%b arithmetic.
module tb_mac_seq_divider;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;

    mac_seq_divider_if #(.P(4))  bus4  ();
    mac_seq_divider_if #(.P(8))  bus8  ();
    mac_seq_divider_if #(.P(16)) bus16 ();

    mac_seq_divider #(.P(4))  u_div4  (.CLK(CLK), .RST(RST), .bus(bus4));
    mac_seq_divider #(.P(8))  u_div8  (.CLK(CLK), .RST(RST), .bus(bus8));
    mac_seq_divider #(.P(16)) u_div16 (.CLK(CLK), .RST(RST), .bus(bus16));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic iv, input logic [15:0] a,
                         input logic [15:0] b, input logic ordy);
        case (w)
            4: begin
                bus4.InValid = iv; bus4.Dividend = a[3:0]; bus4.Divisor = b[3:0]; bus4.OutReady = ordy;
            end
            8: begin
                bus8.InValid = iv; bus8.Dividend = a[7:0]; bus8.Divisor = b[7:0]; bus8.OutReady = ordy;
            end
            default: begin
                bus16.InValid = iv; bus16.Dividend = a; bus16.Divisor = b; bus16.OutReady = ordy;
            end
        endcase
    endtask

    task automatic sample(input int w, output logic [15:0] q, output logic [15:0] r,
                          output logic ov, output logic ir, output logic dz);
        dz = 1'b0;
        case (w)
            4: begin
                q = 16'(bus4.Quotient); r = 16'(bus4.Remainder); ov = bus4.OutValid; ir = bus4.InReady;
`ifdef DIV_ZERO_FLAG_EN
                dz = bus4.DivZero;
`endif
            end
            8: begin
                q = 16'(bus8.Quotient); r = 16'(bus8.Remainder); ov = bus8.OutValid; ir = bus8.InReady;
`ifdef DIV_ZERO_FLAG_EN
                dz = bus8.DivZero;
`endif
            end
            default: begin
                q = bus16.Quotient; r = bus16.Remainder; ov = bus16.OutValid; ir = bus16.InReady;
`ifdef DIV_ZERO_FLAG_EN
                dz = bus16.DivZero;
`endif
            end
        endcase
    endtask

    // One full transaction: accept, count latency, check result, optional back-pressure, retire.
    task automatic run_div(input int w, input logic [15:0] a_in, input logic [15:0] b_in,
                           input int hold, input bit noise);
        logic [15:0] mask, a, b, exp_q, exp_r, q, r;
        logic        ov, ir, dz, ordy;
        int          lat;
        mask  = 16'((32'd1 << w) - 32'd1);
        a     = a_in & mask;
        b     = b_in & mask;
        exp_q = (b == 16'd0) ? mask : a / b;
        exp_r = (b == 16'd0) ? a : a % b;
        ordy  = (hold == 0);

        sample(w, q, r, ov, ir, dz);
        check("in_ready_before_accept", 32'(ir), 32'd1);
        drive(w, 1'b1, a, b, ordy);
        @(posedge CLK); #1;
        drive(w, 1'b0, 16'd0, 16'd0, ordy);

        lat = 0;
        sample(w, q, r, ov, ir, dz);
        while (!ov && lat < 64) begin
            if (noise) drive(w, lat[0], 16'($urandom), 16'($urandom), ordy);
            @(posedge CLK); #1;
            lat++;
            sample(w, q, r, ov, ir, dz);
        end
        drive(w, 1'b0, 16'd0, 16'd0, ordy);

        check("wait_expired", 32'(ov), 32'd1);
        check("latency", 32'(lat), 32'(w));
        check("quotient", 32'(q), 32'(exp_q));
        check("remainder", 32'(r), 32'(exp_r));
`ifdef DIV_ZERO_FLAG_EN
        check("div_zero", 32'(dz), 32'(b == 16'd0));
`endif

        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            sample(w, q, r, ov, ir, dz);
            check("hold_out_valid", 32'(ov), 32'd1);
            check("hold_in_ready", 32'(ir), 32'd0);
            check("hold_quotient", 32'(q), 32'(exp_q));
            check("hold_remainder", 32'(r), 32'(exp_r));
        end
        if (hold > 0) drive(w, 1'b0, 16'd0, 16'd0, 1'b1);

        @(posedge CLK); #1;
        sample(w, q, r, ov, ir, dz);
        check("retire_out_valid", 32'(ov), 32'd0);
        check("retire_in_ready", 32'(ir), 32'd1);
    endtask

    initial begin
        logic [15:0] q, r;
        logic        ov, ir, dz;

        drive(4, 1'b0, 16'd0, 16'd0, 1'b1);
        drive(8, 1'b0, 16'd0, 16'd0, 1'b1);
        drive(16, 1'b0, 16'd0, 16'd0, 1'b1);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int w = 4; w <= 16; w = w * 2) begin
            sample(w, q, r, ov, ir, dz);
            check("reset_in_ready", 32'(ir), 32'd1);
            check("reset_out_valid", 32'(ov), 32'd0);
            check("reset_quotient", 32'(q), 32'd0);
            check("reset_remainder", 32'(r), 32'd0);
            check("reset_div_zero", 32'(dz), 32'd0);
        end

        run_div(8, 16'd100, 16'd7, 0, 1'b1);
        run_div(8, 16'd5, 16'd9, 0, 1'b0);
        run_div(8, 16'd255, 16'd1, 0, 1'b0);
        run_div(8, 16'd255, 16'd255, 0, 1'b0);
        run_div(8, 16'd77, 16'd0, 5, 1'b1);

        // Abort mid-divide: reset lands on the 4th busy cycle.
        drive(8, 1'b1, 16'd123, 16'd5, 1'b1);
        @(posedge CLK); #1;
        drive(8, 1'b0, 16'd0, 16'd0, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        sample(8, q, r, ov, ir, dz);
        check("abort_in_ready", 32'(ir), 32'd1);
        check("abort_out_valid", 32'(ov), 32'd0);
        check("abort_quotient", 32'(q), 32'd0);
        check("abort_remainder", 32'(r), 32'd0);
        check("abort_div_zero", 32'(dz), 32'd0);
        run_div(8, 16'd200, 16'd3, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_div(4, 16'($urandom), 16'($urandom_range(0, 15)), int'($urandom_range(0, 2)), n[0]);
        end
        for (int n = 0; n < 40; n++) begin
            run_div(16, 16'($urandom), (n % 8 == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 15)),
                    int'($urandom_range(0, 2)), n[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
